// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: opcode encodings, ROB entry layout and default sizes.
// The reorder buffer's optional operand lookup ports are enabled with ROB_FWD_EN.
package tomasulo_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int ROB_IDX_W = 3;
   localparam int DATA_W    = 16;
   localparam int REG_W     = 4;
   localparam int ADDR_W    = 8;
   localparam int FUNC_W    = 4;

   localparam logic [FUNC_W-1:0] OP_ADD   = 4'd0;
   localparam logic [FUNC_W-1:0] OP_SUB   = 4'd1;
   localparam logic [FUNC_W-1:0] OP_MUL   = 4'd2;
   localparam logic [FUNC_W-1:0] OP_DIV   = 4'd3;
   localparam logic [FUNC_W-1:0] OP_LOAD  = 4'd4;
   localparam logic [FUNC_W-1:0] OP_STORE = 4'd5;
   localparam logic [FUNC_W-1:0] OP_BEQ   = 4'd6;
   localparam logic [FUNC_W-1:0] OP_BNEQ  = 4'd7;

   // busy/done live outside the struct so they can be reset and flushed as bit vectors
   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              taken;
   } rob_entry_t;

   function automatic logic is_branch(input logic [FUNC_W-1:0] f);
      return (f == OP_BEQ) || (f == OP_BNEQ);
   endfunction

   function automatic logic writes_reg(input logic [FUNC_W-1:0] f);
      return (f == OP_ADD) || (f == OP_SUB) || (f == OP_MUL) ||
             (f == OP_DIV) || (f == OP_LOAD);
   endfunction

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrap-around ROB pointer: increments modulo 2**IDX_W, clear has priority over increment.
module rob_ptr_ctr #(
   parameter int IDX_W = 3
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [IDX_W-1:0] ptr
);

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + IDX_W'(1);
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: in-order retirement of register writes, stores and
// taken-branch flushes. Define ROB_FWD_EN to add two combinational operand lookup ports.
module reorder_buffer
   import tomasulo_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int IDX_W = ROB_IDX_W
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [FUNC_W-1:0] alloc_func,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic [IDX_W-1:0]  alloc_idx,
   input  logic              cdb_valid,
   input  logic [IDX_W-1:0]  cdb_rob_idx,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [ADDR_W-1:0] cdb_addr,
   input  logic              cdb_taken,
   output logic              commit_valid,
   output logic [IDX_W-1:0]  commit_idx,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [ADDR_W-1:0] commit_addr,
   output logic              commit_wr_reg,
   output logic              commit_store,
   output logic              flush,
   output logic [REG_W-1:0]  redirect_pc,
   output logic [IDX_W:0]    count
`ifdef ROB_FWD_EN
   ,
   input  logic [IDX_W-1:0]  src1_idx,
   input  logic [IDX_W-1:0]  src2_idx,
   output logic              src1_rdy,
   output logic              src2_rdy,
   output logic [DATA_W-1:0] src1_data,
   output logic [DATA_W-1:0] src2_data
`endif
);

   logic [DEPTH-1:0] busy_reg;
   logic [DEPTH-1:0] done_reg;
   rob_entry_t       entries [DEPTH];
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [IDX_W:0]   count_reg;
   logic [IDX_W:0]   count_next;
   rob_entry_t       head_entry;
   logic             alloc_go;
   logic             cdb_go;
   logic             commit_fire;
   logic             mispredict;

   assign head_entry  = entries[head];
   assign alloc_ready = (count_reg != (IDX_W+1)'(DEPTH));
   assign alloc_idx   = tail;
   assign count       = count_reg;

   // A CDB write landing on the head defers its retirement so the newer value is what commits
   assign commit_fire = busy_reg[head] && done_reg[head] &&
                        !(cdb_valid && (cdb_rob_idx == head));
   assign mispredict  = commit_fire && is_branch(head_entry.func) && head_entry.taken;
   assign alloc_go    = alloc_valid && alloc_ready && !mispredict;
   assign cdb_go      = cdb_valid && busy_reg[cdb_rob_idx] && !mispredict;

   rob_ptr_ctr #(.IDX_W(IDX_W)) u_head (
      .clk1  (clk1),
      .rst_n (rst_n),
      .inc   (commit_fire),
      .clr   (mispredict),
      .ptr   (head)
   );

   rob_ptr_ctr #(.IDX_W(IDX_W)) u_tail (
      .clk1  (clk1),
      .rst_n (rst_n),
      .inc   (alloc_go),
      .clr   (mispredict),
      .ptr   (tail)
   );

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg <= '0;
         done_reg <= '0;
      end else if (mispredict) begin
         busy_reg <= '0;
         done_reg <= '0;
      end else begin
         if (commit_fire) begin
            busy_reg[head] <= 1'b0;
            done_reg[head] <= 1'b0;
         end
         if (cdb_go) begin
            done_reg[cdb_rob_idx] <= 1'b1;
         end
         if (alloc_go) begin
            busy_reg[tail] <= 1'b1;
            done_reg[tail] <= 1'b0;
         end
      end
   end

   // Payload fields are qualified by busy/done, so they need no reset
   always_ff @(posedge clk1) begin
      if (alloc_go) begin
         entries[tail].func <= alloc_func;
         entries[tail].rd   <= alloc_rd;
      end
      if (cdb_go) begin
         entries[cdb_rob_idx].data  <= cdb_data;
         entries[cdb_rob_idx].addr  <= cdb_addr;
         entries[cdb_rob_idx].taken <= cdb_taken;
      end
   end

   always_comb begin
      count_next = count_reg;
      if (mispredict) begin
         count_next = '0;
      end else if (alloc_go && !commit_fire) begin
         count_next = count_reg + (IDX_W+1)'(1);
      end else if (!alloc_go && commit_fire) begin
         count_next = count_reg - (IDX_W+1)'(1);
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         count_reg     <= '0;
         commit_valid  <= 1'b0;
         commit_idx    <= '0;
         commit_rd     <= '0;
         commit_data   <= '0;
         commit_addr   <= '0;
         commit_wr_reg <= 1'b0;
         commit_store  <= 1'b0;
         flush         <= 1'b0;
         redirect_pc   <= '0;
      end else begin
         count_reg     <= count_next;
         commit_valid  <= commit_fire;
         commit_idx    <= commit_fire ? head : '0;
         commit_rd     <= commit_fire ? head_entry.rd : '0;
         commit_data   <= commit_fire ? head_entry.data : '0;
         commit_addr   <= commit_fire ? head_entry.addr : '0;
         commit_wr_reg <= commit_fire && writes_reg(head_entry.func);
         commit_store  <= commit_fire && (head_entry.func == OP_STORE);
         flush         <= mispredict;
         redirect_pc   <= mispredict ? head_entry.rd : '0;
      end
   end

`ifdef ROB_FWD_EN
   logic src1_hit;
   logic src2_hit;

   assign src1_hit  = cdb_valid && (cdb_rob_idx == src1_idx) && busy_reg[src1_idx];
   assign src2_hit  = cdb_valid && (cdb_rob_idx == src2_idx) && busy_reg[src2_idx];
   assign src1_rdy  = src1_hit || (busy_reg[src1_idx] && done_reg[src1_idx]);
   assign src2_rdy  = src2_hit || (busy_reg[src2_idx] && done_reg[src2_idx]);
   assign src1_data = src1_hit ? cdb_data : entries[src1_idx].data;
   assign src2_data = src2_hit ? cdb_data : entries[src2_idx].data;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation, writeback, in-order commit,
// full/wrap behaviour, stores, taken-branch flush and asynchronous reset.
module tb_reorder_buffer;
   import tomasulo_pkg::*;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [3:0]  alloc_func;
   logic [3:0]  alloc_rd;
   logic [2:0]  alloc_idx;
   logic        cdb_valid;
   logic [2:0]  cdb_rob_idx;
   logic [15:0] cdb_data;
   logic [7:0]  cdb_addr;
   logic        cdb_taken;
   logic        commit_valid;
   logic [2:0]  commit_idx;
   logic [3:0]  commit_rd;
   logic [15:0] commit_data;
   logic [7:0]  commit_addr;
   logic        commit_wr_reg;
   logic        commit_store;
   logic        flush;
   logic [3:0]  redirect_pc;
   logic [3:0]  count;
`ifdef ROB_FWD_EN
   logic [2:0]  src1_idx = 3'd0;
   logic [2:0]  src2_idx = 3'd0;
   logic        src1_rdy;
   logic        src2_rdy;
   logic [15:0] src1_data;
   logic [15:0] src2_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]  idx;
      logic [3:0]  rd;
      logic [15:0] data;
      logic [7:0]  addr;
      logic        wr_reg;
      logic        store;
      logic        flush;
      logic [3:0]  pc;
   } cm_t;

   cm_t log_q[$];

   always #5 clk1 = ~clk1;

   reorder_buffer dut (
      .clk1          (clk1),
      .rst_n         (rst_n),
      .alloc_valid   (alloc_valid),
      .alloc_ready   (alloc_ready),
      .alloc_func    (alloc_func),
      .alloc_rd      (alloc_rd),
      .alloc_idx     (alloc_idx),
      .cdb_valid     (cdb_valid),
      .cdb_rob_idx   (cdb_rob_idx),
      .cdb_data      (cdb_data),
      .cdb_addr      (cdb_addr),
      .cdb_taken     (cdb_taken),
      .commit_valid  (commit_valid),
      .commit_idx    (commit_idx),
      .commit_rd     (commit_rd),
      .commit_data   (commit_data),
      .commit_addr   (commit_addr),
      .commit_wr_reg (commit_wr_reg),
      .commit_store  (commit_store),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .count         (count)
`ifdef ROB_FWD_EN
      ,
      .src1_idx      (src1_idx),
      .src2_idx      (src2_idx),
      .src1_rdy      (src1_rdy),
      .src2_rdy      (src2_rdy),
      .src1_data     (src1_data),
      .src2_data     (src2_data)
`endif
   );

   always @(negedge clk1) begin
      if (commit_valid === 1'b1) begin
         log_q.push_back('{commit_idx, commit_rd, commit_data, commit_addr,
                           commit_wr_reg, commit_store, flush, redirect_pc});
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic do_alloc(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] exp_idx);
      alloc_valid = 1'b1;
      alloc_func  = f;
      alloc_rd    = rd;
      #1;
      check("alloc_idx", 64'(alloc_idx), 64'(exp_idx));
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [2:0] idx, input logic [15:0] d, input logic [7:0] a,
                         input logic t);
      cdb_valid   = 1'b1;
      cdb_rob_idx = idx;
      cdb_data    = d;
      cdb_addr    = a;
      cdb_taken   = t;
      tick();
      cdb_valid   = 1'b0;
   endtask

   task automatic expect_commit(input string tag, input cm_t exp);
      if (log_q.size() == 0) begin
         check({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         check(tag, 64'(log_q.pop_front()), 64'(exp));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
      cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0; cdb_addr = '0; cdb_taken = 1'b0;
      repeat (2) @(posedge clk1);
      #1;
      check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_alloc_idx", 64'(alloc_idx), 64'd0);
      rst_n = 1'b1;
      tick();

      // three allocations
      do_alloc(OP_ADD, 4'd1, 3'd0);
      do_alloc(OP_SUB, 4'd2, 3'd1);
      do_alloc(OP_MUL, 4'd3, 3'd2);
      check("alloc3_count", 64'(count), 64'd3);
      check("alloc3_no_commit", 64'(commit_valid), 64'd0);

      // out-of-order writeback, in-order commit
      do_cdb(3'd1, 16'h0005, 8'h00, 1'b0);
      check("cdb1_no_commit", 64'(commit_valid), 64'd0);
      do_cdb(3'd0, 16'h0007, 8'h00, 1'b0);
      check("cdb0_edge_no_commit", 64'(commit_valid), 64'd0);
      tick();
      check("c0_valid", 64'(commit_valid), 64'd1);
      check("c0_idx", 64'(commit_idx), 64'd0);
      check("c0_rd", 64'(commit_rd), 64'd1);
      check("c0_data", 64'(commit_data), 64'h0007);
      check("c0_wr_reg", 64'(commit_wr_reg), 64'd1);
      check("c0_store", 64'(commit_store), 64'd0);
      tick();
      check("c1_valid", 64'(commit_valid), 64'd1);
      check("c1_idx", 64'(commit_idx), 64'd1);
      check("c1_rd", 64'(commit_rd), 64'd2);
      check("c1_data", 64'(commit_data), 64'h0005);
      tick();
      check("c2_idle", 64'(commit_valid), 64'd0);
      check("c2_count", 64'(count), 64'd1);

      // fill to 8 with tail wrapping 7->0
      for (int i = 3; i < 8; i++) do_alloc(OP_ADD, 4'(i), 3'(i));
      do_alloc(OP_STORE, 4'd0, 3'd0);
      do_alloc(OP_ADD, 4'd1, 3'd1);
      check("full_count", 64'(count), 64'd8);
      check("full_ready", 64'(alloc_ready), 64'd0);
      do_cdb(3'd2, 16'h0033, 8'h00, 1'b0);
      alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'hA;
      #1;
      check("full_ready_commit_cycle", 64'(alloc_ready), 64'd0);
      tick();
      check("full_commit_valid", 64'(commit_valid), 64'd1);
      check("full_commit_idx", 64'(commit_idx), 64'd2);
      check("full_commit_data", 64'(commit_data), 64'h0033);
      check("full_no_alloc_count", 64'(count), 64'd7);
      check("after_full_ready", 64'(alloc_ready), 64'd1);
      check("after_full_alloc_idx", 64'(alloc_idx), 64'd2);
      tick();
      alloc_valid = 1'b0;
      check("refill_count", 64'(count), 64'd8);

      // store plus a stream of back-to-back commits
      log_q.delete();
      do_cdb(3'd0, 16'h1234, 8'h2A, 1'b0);
      for (int i = 3; i < 8; i++) do_cdb(3'(i), 16'h0100 + 16'(i), 8'h00, 1'b0);
      do_cdb(3'd1, 16'h0011, 8'h00, 1'b0);
      repeat (4) tick();
      check("stream_commits", 64'(log_q.size()), 64'd7);
      for (int i = 3; i < 8; i++)
         expect_commit("stream_add", '{3'(i), 4'(i), 16'h0100 + 16'(i), 8'h00, 1'b1, 1'b0, 1'b0, 4'h0});
      expect_commit("store_commit", '{3'd0, 4'd0, 16'h1234, 8'h2A, 1'b0, 1'b1, 1'b0, 4'h0});
      expect_commit("stream_last", '{3'd1, 4'd1, 16'h0011, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0});
      check("stream_count", 64'(count), 64'd1);

      // CDB write to a done head on the commit edge defers the commit
      do_cdb(3'd2, 16'h00AA, 8'h00, 1'b0);
      cdb_valid = 1'b1; cdb_rob_idx = 3'd2; cdb_data = 16'h00BB;
      tick();
      cdb_valid = 1'b0;
      check("head_cdb_defers", 64'(commit_valid), 64'd0);
      tick();
      check("head_cdb_commit", 64'(commit_valid), 64'd1);
      check("head_cdb_data", 64'(commit_data), 64'h00BB);
      check("head_cdb_count", 64'(count), 64'd0);

      // taken branch at head with three younger entries
      do_alloc(OP_BEQ, 4'h9, 3'd3);
      do_alloc(OP_ADD, 4'd4, 3'd4);
      do_alloc(OP_ADD, 4'd5, 3'd5);
      do_alloc(OP_ADD, 4'd6, 3'd6);
      check("br_count", 64'(count), 64'd4);
      do_cdb(3'd4, 16'h0044, 8'h00, 1'b0);
      do_cdb(3'd3, 16'h0000, 8'h00, 1'b1);
      alloc_valid = 1'b1; alloc_func = OP_ADD; alloc_rd = 4'hF;
      cdb_valid = 1'b1; cdb_rob_idx = 3'd5; cdb_data = 16'h0055; cdb_taken = 1'b0;
      tick();
      alloc_valid = 1'b0; cdb_valid = 1'b0;
      check("flush", 64'(flush), 64'd1);
      check("flush_redirect", 64'(redirect_pc), 64'h9);
      check("flush_commit_valid", 64'(commit_valid), 64'd1);
      check("flush_commit_idx", 64'(commit_idx), 64'd3);
      check("flush_wr_reg", 64'(commit_wr_reg), 64'd0);
      check("flush_count", 64'(count), 64'd0);
      check("flush_alloc_idx", 64'(alloc_idx), 64'd0);
      tick();
      check("flush_pulse_end", 64'(flush), 64'd0);
      log_q.delete();
      do_cdb(3'd0, 16'hDEAD, 8'h00, 1'b0);
      do_cdb(3'd4, 16'hBEEF, 8'h00, 1'b0);
      check("stale_count", 64'(count), 64'd0);
      do_alloc(OP_ADD, 4'd2, 3'd0);
      repeat (3) tick();
      check("stale_cdb_ignored", 64'(log_q.size()), 64'd0);
      check("stale_alloc_count", 64'(count), 64'd1);

      // asynchronous reset with 5 entries pending and a commit in flight
      for (int i = 1; i < 5; i++) do_alloc(OP_ADD, 4'(i), 3'(i));
      check("pre_rst_count", 64'(count), 64'd5);
      do_cdb(3'd0, 16'h0777, 8'h00, 1'b0);
      cdb_valid = 1'b1; cdb_rob_idx = 3'd1; cdb_data = 16'h0888;
      tick();
      cdb_valid = 1'b0;
      check("pre_rst_commit", 64'(commit_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_async_commit_data", 64'(commit_data), 64'd0);
      check("rst_async_wr_reg", 64'(commit_wr_reg), 64'd0);
      check("rst_async_count", 64'(count), 64'd0);
      check("rst_async_ready", 64'(alloc_ready), 64'd1);
      check("rst_async_alloc_idx", 64'(alloc_idx), 64'd0);
      log_q.delete();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_no_commit", 64'(log_q.size()), 64'd0);
      check("post_rst_count", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
